// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: load-use hazard detection, bubble insertion,
// downstream stall hold and a saturating bubble counter.
module id_ex_reg #(
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [4:0]         rs1_i,
  input  logic [4:0]         rs2_i,
  input  logic               reg_read1_e_i,
  input  logic               reg_read2_e_i,
  input  logic [31:0]        rs1_data_i,
  input  logic [31:0]        rs2_data_i,
  input  logic               branch_i,
  input  logic               mem_read_i,
  input  logic               mem_to_reg_i,
  input  logic               mem_write_i,
  input  logic               alu_src_i,
  input  logic               reg_write_i,
  input  logic [ALUOP_W-1:0] alu_op_i,
  input  logic [31:0]        r_imm_i,
  input  logic [31:0]        s_imm_i,
  input  logic [31:0]        b_imm_i,
  input  logic [4:0]         rd_i,
  input  logic [31:0]        pc_i,
  output logic               valid_o,
  output logic [4:0]         rs1_o,
  output logic [4:0]         rs2_o,
  output logic [4:0]         rd_o,
  output logic [31:0]        rs1_data_o,
  output logic [31:0]        rs2_data_o,
  output logic [31:0]        r_imm_o,
  output logic [31:0]        s_imm_o,
  output logic [31:0]        b_imm_o,
  output logic [31:0]        pc_o,
  output logic               branch_o,
  output logic               mem_read_o,
  output logic               mem_to_reg_o,
  output logic               mem_write_o,
  output logic               alu_src_o,
  output logic               reg_write_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               hazard_stall_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  typedef struct packed {
    logic               valid;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [31:0]        rs1_data;
    logic [31:0]        rs2_data;
    logic [31:0]        r_imm;
    logic [31:0]        s_imm;
    logic [31:0]        b_imm;
    logic [31:0]        pc;
    logic               branch;
    logic               mem_read;
    logic               mem_to_reg;
    logic               mem_write;
    logic               alu_src;
    logic               reg_write;
    logic [ALUOP_W-1:0] alu_op;
  } id_ex_t;

  id_ex_t d, q;
  logic [CNT_W-1:0] cnt;
  logic hazard;
  logic bubble;
  logic sat;

  assign d = '{
    valid:      valid_i,
    rs1:        rs1_i,
    rs2:        rs2_i,
    rd:         rd_i,
    rs1_data:   rs1_data_i,
    rs2_data:   rs2_data_i,
    r_imm:      r_imm_i,
    s_imm:      s_imm_i,
    b_imm:      b_imm_i,
    pc:         pc_i,
    branch:     branch_i,
    mem_read:   mem_read_i,
    mem_to_reg: mem_to_reg_i,
    mem_write:  mem_write_i,
    alu_src:    alu_src_i,
    reg_write:  reg_write_i,
    alu_op:     alu_op_i
  };

  // x0 never creates a real dependency, so rd == 0 cannot stall
  assign hazard = q.valid & q.mem_read & (q.rd != 5'd0) & valid_i &
                  ((reg_read1_e_i & (rs1_i == q.rd)) |
                   (reg_read2_e_i & (rs2_i == q.rd)));

  assign hazard_stall_o = hazard;
  assign bubble = flush_i | (~stall_i & hazard);
  assign sat    = (cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      q   <= '0;
      cnt <= '0;
    end else if (bubble) begin
      q <= '0;
      if (!sat) cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (!stall_i) begin
      q <= d;
    end
  end

  assign valid_o      = q.valid;
  assign rs1_o        = q.rs1;
  assign rs2_o        = q.rs2;
  assign rd_o         = q.rd;
  assign rs1_data_o   = q.rs1_data;
  assign rs2_data_o   = q.rs2_data;
  assign r_imm_o      = q.r_imm;
  assign s_imm_o      = q.s_imm;
  assign b_imm_o      = q.b_imm;
  assign pc_o         = q.pc;
  assign branch_o     = q.branch;
  assign mem_read_o   = q.mem_read;
  assign mem_to_reg_o = q.mem_to_reg;
  assign mem_write_o  = q.mem_write;
  assign alu_src_o    = q.alu_src;
  assign reg_write_o  = q.reg_write;
  assign alu_op_o     = q.alu_op;
  assign bubble_cnt_o = cnt;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg, counter narrowed to 4 bits
// so saturation is reachable quickly.
module tb_id_ex_reg;

  localparam int AW = 2;
  localparam int CW = 4;

  logic clk = 0;
  logic rst, valid, stall, flush;
  logic [4:0] rs1, rs2, rd;
  logic re1, re2;
  logic [31:0] d1, d2, ri, si, bi, pc;
  logic br, mr, m2r, mw, as, rw;
  logic [AW-1:0] op;

  logic v_o;
  logic [4:0] rs1_o, rs2_o, rd_o;
  logic [31:0] d1_o, d2_o, ri_o, si_o, bi_o, pc_o;
  logic br_o, mr_o, m2r_o, mw_o, as_o, rw_o;
  logic [AW-1:0] op_o;
  logic hz;
  logic [CW-1:0] cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.ALUOP_W(AW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid),
    .stall_i(stall), .flush_i(flush),
    .rs1_i(rs1), .rs2_i(rs2),
    .reg_read1_e_i(re1), .reg_read2_e_i(re2),
    .rs1_data_i(d1), .rs2_data_i(d2),
    .branch_i(br), .mem_read_i(mr),
    .mem_to_reg_i(m2r), .mem_write_i(mw),
    .alu_src_i(as), .reg_write_i(rw),
    .alu_op_i(op), .r_imm_i(ri), .s_imm_i(si),
    .b_imm_i(bi), .rd_i(rd), .pc_i(pc),
    .valid_o(v_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .rd_o(rd_o), .rs1_data_o(d1_o),
    .rs2_data_o(d2_o), .r_imm_o(ri_o),
    .s_imm_o(si_o), .b_imm_o(bi_o), .pc_o(pc_o),
    .branch_o(br_o), .mem_read_o(mr_o),
    .mem_to_reg_o(m2r_o), .mem_write_o(mw_o),
    .alu_src_o(as_o), .reg_write_o(rw_o),
    .alu_op_o(op_o), .hazard_stall_o(hz),
    .bubble_cnt_o(cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rst = 1; valid = 0; stall = 0; flush = 0;
    rs1 = 0; rs2 = 0; rd = 0; re1 = 0; re2 = 0;
    d1 = 0; d2 = 0; ri = 0; si = 0; bi = 0; pc = 0;
    br = 0; mr = 0; m2r = 0; mw = 0; as = 0; rw = 0;
    op = 0;
  endtask

  task automatic test_reset();
    clr();
    rst = 0; valid = 1; pc = 32'h55; mr = 1; rd = 3;
    rw = 1; d1 = 32'hdead; op = 2'd3; br = 1;
    tick(); tick();
    total++;
    if (v_o !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b want=0", v_o);
    end
    total++;
    if ({pc_o, d1_o, ri_o} !== 96'h0) begin
      bad++; $display("FAIL rst_data got=%h want=0", {pc_o, d1_o, ri_o});
    end
    total++;
    if ({rd_o, rw_o, mr_o, br_o, op_o} !== 10'h0) begin
      bad++; $display("FAIL rst_ctrl got=%h want=0",
                      {rd_o, rw_o, mr_o, br_o, op_o});
    end
    total++;
    if (cnt !== 4'd0) begin
      bad++; $display("FAIL rst_cnt got=%0d want=0", cnt);
    end
    clr();
    valid = 1; pc = 32'h100;
    tick();
    total++;
    if (pc_o !== 32'h100 || v_o !== 1'b1) begin
      bad++; $display("FAIL rst_first got=%h/%b want=100/1", pc_o, v_o);
    end
  endtask

  task automatic test_pass();
    clr();
    valid = 1; rd = 1; ri = 5; rw = 1; as = 1;
    re1 = 1; pc = 32'h104; si = 32'h77; bi = 32'h88;
    d1 = 32'h11; d2 = 32'h22; op = 2'd2; rs2 = 5'd4;
    tick();
    total++;
    if ({v_o, rd_o, rw_o, as_o} !== {1'b1, 5'd1, 1'b1, 1'b1}) begin
      bad++; $display("FAIL pass_ctrl got=%b%h%b%b want=1 01 1 1",
                      v_o, rd_o, rw_o, as_o);
    end
    total++;
    if ({ri_o, si_o, bi_o} !== {32'd5, 32'h77, 32'h88}) begin
      bad++; $display("FAIL pass_imm got=%h want=5/77/88",
                      {ri_o, si_o, bi_o});
    end
    total++;
    if ({d1_o, d2_o, pc_o, op_o, rs2_o} !==
        {32'h11, 32'h22, 32'h104, 2'd2, 5'd4}) begin
      bad++; $display("FAIL pass_data got=%h %h %h %h %h",
                      d1_o, d2_o, pc_o, op_o, rs2_o);
    end
  endtask

  task automatic test_load_use();
    clr();
    valid = 1; mr = 1; m2r = 1; rw = 1; rd = 5;
    rs1 = 2; re1 = 1; pc = 32'h200;
    tick();
    clr();
    valid = 1; rs1 = 5; rs2 = 3; re1 = 1; re2 = 1;
    rd = 6; rw = 1; pc = 32'h204;
    #1;
    total++;
    if (hz !== 1'b1) begin
      bad++; $display("FAIL lu_hz got=%b want=1", hz);
    end
    tick();
    total++;
    if ({v_o, rw_o, hz} !== 3'b000) begin
      bad++; $display("FAIL lu_bubble got=%b want=000", {v_o, rw_o, hz});
    end
    total++;
    if (cnt !== 4'd1) begin
      bad++; $display("FAIL lu_cnt got=%0d want=1", cnt);
    end
    tick();
    total++;
    if ({v_o, pc_o, rd_o} !== {1'b1, 32'h204, 5'd6}) begin
      bad++; $display("FAIL lu_add got=%b %h %0d want=1 204 6",
                      v_o, pc_o, rd_o);
    end
    // load into x0: dependency on x0 is ignored
    clr();
    valid = 1; mr = 1; rw = 1; rd = 0; pc = 32'h208;
    tick();
    clr();
    valid = 1; rs1 = 0; re1 = 1; rd = 7; pc = 32'h20c;
    #1;
    total++;
    if (hz !== 1'b0) begin
      bad++; $display("FAIL lu_x0_hz got=%b want=0", hz);
    end
    tick();
    total++;
    if ({pc_o, cnt} !== {32'h20c, 4'd1}) begin
      bad++; $display("FAIL lu_x0 got=%h %0d want=20c 1", pc_o, cnt);
    end
    // invalid decode slot with matching source: no hazard
    clr();
    valid = 1; mr = 1; rw = 1; rd = 7; pc = 32'h210;
    tick();
    clr();
    valid = 0; rs1 = 7; re1 = 1; rw = 1; pc = 32'h214;
    #1;
    total++;
    if (hz !== 1'b0) begin
      bad++; $display("FAIL lu_inv_hz got=%b want=0", hz);
    end
    tick();
    total++;
    if ({v_o, rw_o, pc_o, cnt} !== {1'b0, 1'b1, 32'h214, 4'd1}) begin
      bad++; $display("FAIL lu_inv got=%b %b %h %0d want=0 1 214 1",
                      v_o, rw_o, pc_o, cnt);
    end
  endtask

  task automatic test_stall();
    clr();
    valid = 1; pc = 32'h300; rd = 9; ri = 32'h1234; rw = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      clr();
      stall = 1; valid = 1; pc = 32'h400 + i;
      rd = 5'(i + 12); ri = 32'hffff; rw = 0;
      tick();
      total++;
      if ({v_o, pc_o, rd_o, ri_o, rw_o, cnt} !==
          {1'b1, 32'h300, 5'd9, 32'h1234, 1'b1, 4'd1}) begin
        bad++; $display("FAIL stall_hold%0d got=%b %h %0d %h %b %0d",
                        i, v_o, pc_o, rd_o, ri_o, rw_o, cnt);
      end
    end
  endtask

  task automatic test_flush_stall();
    clr();
    flush = 1; stall = 1; valid = 1; pc = 32'h500; rd = 4;
    tick();
    total++;
    if ({v_o, pc_o, rd_o, rw_o, cnt} !==
        {1'b0, 32'h0, 5'd0, 1'b0, 4'd2}) begin
      bad++; $display("FAIL flush_stall got=%b %h %0d %b %0d want=0 0 0 0 2",
                      v_o, pc_o, rd_o, rw_o, cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    clr();
    valid = 1; pc = 32'h600; rd = 3;
    tick();
    stall = 1; rst = 0;
    tick();
    total++;
    if ({v_o, pc_o, rd_o, cnt} !== {1'b0, 32'h0, 5'd0, 4'd0}) begin
      bad++; $display("FAIL rst_stall got=%b %h %0d %0d want=0 0 0 0",
                      v_o, pc_o, rd_o, cnt);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    clr();
    flush = 1; valid = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_cnt = (i + 1 > 15) ? 15 : i + 1;
      total++;
      if (cnt !== 4'(exp_cnt)) begin
        bad++; $display("FAIL sat_%0d got=%0d want=%0d", i, cnt, exp_cnt);
      end
    end
    clr();
    valid = 1; pc = 32'h700;
    tick();
    total++;
    if ({cnt, pc_o} !== {4'd15, 32'h700}) begin
      bad++; $display("FAIL sat_after got=%0d %h want=15 700", cnt, pc_o);
    end
  endtask

  initial begin
    clr();
    test_reset();
    test_pass();
    test_load_use();
    test_stall();
    test_flush_stall();
    test_reset_mid_stall();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
